// File: rtl/if_fetch.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch
// Purpose  : Instruction-fetch stage of a five-stage MIPS pipeline. Owns the
//            program counter, drives the combinational instruction ROM and
//            registers the fetched word with its PC into the IF/ID register.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk                      in   pipeline clock, rising edge
//   rst                      in   synchronous active-high reset
//   stall[5:0]               in   stall vector: [0]=PC, [1]=IF, [2]=ID
//   flush                    in   exception flush, redirect to new_pc
//   new_pc[31:0]             in   exception handler / ERET target
//   branch_flag_i            in   taken branch/jump resolved in ID
//   branch_target_address_i  in   branch/jump target
//   rom_ce_o                 out  ROM chip enable (suppressed when misaligned)
//   rom_addr_o[31:0]         out  fetch address (current PC)
//   rom_data_i[31:0]         in   ROM read data (combinational)
//   id_pc_o[31:0]            out  PC of the slot in IF/ID
//   id_inst_o[31:0]          out  instruction in IF/ID (0 = NOP bubble)
//   id_valid_o               out  IF/ID holds a real fetched slot
//   id_adel_o                out  fetch address error for the IF/ID slot
// ============================================================================
module if_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  stall,
   input  logic        flush,
   input  logic [31:0] new_pc,
   input  logic        branch_flag_i,
   input  logic [31:0] branch_target_address_i,
   output logic        rom_ce_o,
   output logic [31:0] rom_addr_o,
   input  logic [31:0] rom_data_i,
   output logic [31:0] id_pc_o,
   output logic [31:0] id_inst_o,
   output logic        id_valid_o,
   output logic        id_adel_o
);

   logic        ce_q;
   logic [31:0] pc_q;
   logic [31:0] id_pc_q;
   logic [31:0] id_inst_q;
   logic        id_valid_q;
   logic        id_adel_q;

   logic        aligned;
   logic        bubble;

   assign aligned    = (pc_q[1:0] == 2'b00);
   // IF stalled while ID keeps moving: ID must see a bubble, not a repeat.
   assign bubble     = stall[1] & ~stall[2];

   assign rom_addr_o = pc_q;
   assign rom_ce_o   = ce_q & aligned;

   assign id_pc_o    = id_pc_q;
   assign id_inst_o  = id_inst_q;
   assign id_valid_o = id_valid_q;
   assign id_adel_o  = id_adel_q;

   // ------------------------------------------------------------------------
   // Program counter and fetch enable
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         ce_q <= 1'b0;
         pc_q <= RESET_PC;
      end else begin
         ce_q <= 1'b1;
         if (!ce_q) begin
            pc_q <= RESET_PC;
         end else if (flush) begin
            pc_q <= new_pc;
         end else if (stall[0]) begin
            pc_q <= pc_q;
         end else if (branch_flag_i) begin
            // The delay slot at pc_q is fetched this cycle; only the
            // following address is redirected.
            pc_q <= branch_target_address_i;
         end else begin
            pc_q <= pc_q + 32'd4;
         end
      end
   end

   // ------------------------------------------------------------------------
   // IF/ID pipeline register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst || flush || !ce_q || bubble) begin
         id_pc_q    <= 32'h0;
         id_inst_q  <= 32'h0;
         id_valid_q <= 1'b0;
         id_adel_q  <= 1'b0;
      end else if (!stall[1]) begin
         // A misaligned fetch becomes a NOP tagged with an address error;
         // the exception stage will flush on it.
         id_pc_q    <= pc_q;
         id_inst_q  <= aligned ? rom_data_i : 32'h0;
         id_valid_q <= 1'b1;
         id_adel_q  <= ~aligned;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_if_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_fetch
// Purpose  : Self-checking bench for if_fetch. A ROM model answers fetches;
//            a behavioural model predicts every output each cycle, and
//            directed steps pin literal expectations.
// Revision : 1.0  initial release
// ============================================================================
module tb_if_fetch;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  stall;
   logic        flush;
   logic [31:0] new_pc;
   logic        branch_flag_i;
   logic [31:0] branch_target_address_i;
   logic        rom_ce_o;
   logic [31:0] rom_addr_o;
   logic [31:0] rom_data_i;
   logic [31:0] id_pc_o;
   logic [31:0] id_inst_o;
   logic        id_valid_o;
   logic        id_adel_o;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   if_fetch #(.RESET_PC(32'h0000_0000)) dut (
      .clk                     (clk),
      .rst                     (rst),
      .stall                   (stall),
      .flush                   (flush),
      .new_pc                  (new_pc),
      .branch_flag_i           (branch_flag_i),
      .branch_target_address_i (branch_target_address_i),
      .rom_ce_o                (rom_ce_o),
      .rom_addr_o              (rom_addr_o),
      .rom_data_i              (rom_data_i),
      .id_pc_o                 (id_pc_o),
      .id_inst_o               (id_inst_o),
      .id_valid_o              (id_valid_o),
      .id_adel_o               (id_adel_o)
   );

   // ROM contents: a distinct, non-zero word per address.
   function automatic logic [31:0] rom_word(input logic [31:0] a);
      return {16'hC0DE ^ a[31:16], a[15:0]};
   endfunction

   // A disabled ROM returns junk so a missing mask on misaligned fetches shows.
   assign rom_data_i = rom_ce_o ? rom_word(rom_addr_o) : 32'hBAD0_BAD0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------------
   // Behavioural model: where fetch goes next and what slot ID receives.
   // ------------------------------------------------------------------------
   logic        m_run;          // fetch has been enabled for at least one edge
   logic [31:0] m_fetch;        // address being fetched
   logic [31:0] m_slot_pc;
   logic [31:0] m_slot_inst;
   logic        m_slot_valid;
   logic        m_slot_adel;
   logic        m_started = 1'b0;

   always @(posedge clk) begin
      m_started <= 1'b1;
      if (rst) begin
         m_run <= 1'b0;
         m_fetch <= 32'h0;
         {m_slot_pc, m_slot_inst, m_slot_valid, m_slot_adel} <= '0;
      end else begin
         m_run <= 1'b1;
         // next fetch address
         if (!m_run)                 m_fetch <= 32'h0;
         else if (flush)             m_fetch <= new_pc;
         else if (stall[0])          m_fetch <= m_fetch;
         else if (branch_flag_i)     m_fetch <= branch_target_address_i;
         else                        m_fetch <= m_fetch + 32'd4;
         // what the decode stage receives
         if (flush || !m_run || (stall[1] && !stall[2]))
            {m_slot_pc, m_slot_inst, m_slot_valid, m_slot_adel} <= '0;
         else if (!stall[1]) begin
            m_slot_pc    <= m_fetch;
            m_slot_valid <= 1'b1;
            m_slot_adel  <= (m_fetch % 4) != 0;
            m_slot_inst  <= ((m_fetch % 4) != 0) ? 32'h0 : rom_word(m_fetch);
         end
      end
   end

   // Every cycle, away from the active edge, compare all outputs.
   always @(negedge clk) begin
      if (m_started) begin
         chk("m_rom_addr", rom_addr_o, m_fetch);
         chk("m_rom_ce", {31'h0, rom_ce_o}, {31'h0, m_run && (m_fetch % 4) == 0});
         chk("m_id_pc", id_pc_o, m_slot_pc);
         chk("m_id_inst", id_inst_o, m_slot_inst);
         chk("m_id_valid", {31'h0, id_valid_o}, {31'h0, m_slot_valid});
         chk("m_id_adel", {31'h0, id_adel_o}, {31'h0, m_slot_adel});
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic lit_id(input string nm, input logic [31:0] pc, input logic [31:0] inst,
                         input logic valid, input logic adel);
      chk({nm, "_pc"}, id_pc_o, pc);
      chk({nm, "_inst"}, id_inst_o, inst);
      chk({nm, "_valid"}, {31'h0, id_valid_o}, {31'h0, valid});
      chk({nm, "_adel"}, {31'h0, id_adel_o}, {31'h0, adel});
   endtask

   // Directed stall patterns replayed at the end, checked by the model.
   logic [5:0] vec_stall [12] = '{6'b000000, 6'b000100, 6'b000011, 6'b000111,
                                  6'b000001, 6'b000110, 6'b111000, 6'b000010,
                                  6'b000000, 6'b000101, 6'b000011, 6'b000000};

   initial begin
      rst = 1'b1; stall = '0; flush = 1'b0; new_pc = '0;
      branch_flag_i = 1'b0; branch_target_address_i = '0;
      step(); step();
      chk("rst_ce", {31'h0, rom_ce_o}, 32'h0);
      chk("rst_addr", rom_addr_o, 32'h0);
      lit_id("rst", 32'h0, 32'h0, 1'b0, 1'b0);

      // reset release: one enable edge, then captures 0,4,8
      rst = 1'b0;
      step();
      chk("en_ce", {31'h0, rom_ce_o}, 32'h1);
      chk("en_addr", rom_addr_o, 32'h0);
      lit_id("en", 32'h0, 32'h0, 1'b0, 1'b0);
      step();
      lit_id("w0", 32'h0, 32'hC0DE_0000, 1'b1, 1'b0);
      step();
      lit_id("w1", 32'h4, 32'hC0DE_0004, 1'b1, 1'b0);
      chk("pre_br_addr", rom_addr_o, 32'h8);

      // branch while delay slot at 8 is fetched
      branch_flag_i = 1'b1; branch_target_address_i = 32'h100;
      step();
      branch_flag_i = 1'b0;
      lit_id("dslot", 32'h8, 32'hC0DE_0008, 1'b1, 1'b0);
      chk("br_addr", rom_addr_o, 32'h100);
      step();
      lit_id("br_tgt", 32'h100, 32'hC0DE_0100, 1'b1, 1'b0);

      // move to 0x10, then full stall for three cycles
      branch_flag_i = 1'b1; branch_target_address_i = 32'h10;
      step();
      branch_flag_i = 1'b0;
      chk("st_pre_addr", rom_addr_o, 32'h10);
      stall = 6'b000111;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("st_hold_addr", rom_addr_o, 32'h10);
         chk("st_hold_pc", id_pc_o, 32'h104);
      end
      stall = 6'b000000;
      step();
      lit_id("st_rel0", 32'h10, 32'hC0DE_0010, 1'b1, 1'b0);
      step();
      lit_id("st_rel1", 32'h14, 32'hC0DE_0014, 1'b1, 1'b0);

      // IF-only stall: bubble, PC held
      stall = 6'b000011;
      step();
      lit_id("bub", 32'h0, 32'h0, 1'b0, 1'b0);
      chk("bub_addr", rom_addr_o, 32'h18);
      stall = 6'b000000;
      step();
      lit_id("bub_rel", 32'h18, 32'hC0DE_0018, 1'b1, 1'b0);

      // flush wins over stall and branch
      flush = 1'b1; new_pc = 32'h20; stall = 6'b000111;
      branch_flag_i = 1'b1; branch_target_address_i = 32'h200;
      step();
      flush = 1'b0; stall = 6'b000000; branch_flag_i = 1'b0;
      chk("fl_addr", rom_addr_o, 32'h20);
      lit_id("fl", 32'h0, 32'h0, 1'b0, 1'b0);
      step();
      lit_id("fl_tgt", 32'h20, 32'hC0DE_0020, 1'b1, 1'b0);

      // misaligned fetch
      branch_flag_i = 1'b1; branch_target_address_i = 32'h102;
      step();
      branch_flag_i = 1'b0;
      chk("mis_ce", {31'h0, rom_ce_o}, 32'h0);
      chk("mis_addr", rom_addr_o, 32'h102);
      step();
      lit_id("mis", 32'h102, 32'h0, 1'b1, 1'b1);
      chk("mis_adv", rom_addr_o, 32'h106);

      // wrap at the top of the address space
      branch_flag_i = 1'b1; branch_target_address_i = 32'hFFFF_FFFC;
      step();
      branch_flag_i = 1'b0;
      chk("wrap_top", rom_addr_o, 32'hFFFF_FFFC);
      step();
      chk("wrap_zero", rom_addr_o, 32'h0);
      lit_id("wrap", 32'hFFFF_FFFC, 32'h3F21_FFFC, 1'b1, 1'b0);

      // stall pattern replay, model-checked
      for (int i = 0; i < 12; i++) begin
         stall = vec_stall[i];
         branch_flag_i = (i == 5) || (i == 9);
         branch_target_address_i = 32'h400 + 32'(i * 16);
         step();
      end
      stall = '0; branch_flag_i = 1'b0;
      step();

      // mid-stream reset beats stall/flush/branch
      rst = 1'b1; stall = 6'b000111; flush = 1'b1; new_pc = 32'h80;
      branch_flag_i = 1'b1; branch_target_address_i = 32'h300;
      step();
      chk("mrst_addr", rom_addr_o, 32'h0);
      chk("mrst_ce", {31'h0, rom_ce_o}, 32'h0);
      lit_id("mrst", 32'h0, 32'h0, 1'b0, 1'b0);
      rst = 1'b0; stall = '0; flush = 1'b0; branch_flag_i = 1'b0;
      step();
      lit_id("mrst_en", 32'h0, 32'h0, 1'b0, 1'b0);
      step();
      lit_id("mrst_w0", 32'h0, 32'hC0DE_0000, 1'b1, 1'b0);
      step(); step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage of the OpenMIPS five-stage pipeline. It owns the program counter and drives the address and chip-enable of the combinational instruction ROM. It latches the returned word together with its PC into the IF/ID pipeline register for the decode stage. It honours the pipeline-wide stall vector, the exception flush/redirect, branch redirects from ID, and detects misaligned fetch addresses.

## Interface
- RESET_PC, 32'h0000_0000, PC value held during reset and for the first fetch.
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset (`RstEnable` = 1'b1).
- stall  in  6  pipeline stall vector; bit0 = PC, bit1 = IF, bit2 = ID (bits 5:3 ignored here).
- flush  in  1  exception flush; redirect to new_pc and squash IF/ID.
- new_pc  in  32  exception handler / ERET target, valid with flush.
- branch_flag_i  in  1  taken branch/jump resolved in ID.
- branch_target_address_i  in  32  branch/jump target, valid with branch_flag_i.
- rom_ce_o  out  1  instruction ROM chip enable (`ChipEnable` = 1).
- rom_addr_o  out  32  fetch address (current PC).
- rom_data_i  in  32  ROM read data, combinational from rom_addr_o/rom_ce_o.
- id_pc_o  out  32  PC of instruction held in IF/ID.
- id_inst_o  out  32  instruction held in IF/ID (0 = NOP bubble).
- id_valid_o  out  1  IF/ID holds a real fetched slot (not a bubble).
- id_adel_o  out  1  fetch address error (PC[1:0] != 0) for the slot in IF/ID.

## Operation
- Registers: ce_q, pc_q[31:0], IF/ID {pc, inst, valid, adel}.
- rom_addr_o = pc_q; rom_ce_o = ce_q & (pc_q[1:0] == 2'b00).
- ce_q: rst → 0; otherwise → 1 on the next edge (first enabled cycle is the cycle after rst drops).
- PC next-value priority:
  - rst → RESET_PC.
  - ce_q == 0 → RESET_PC.
  - flush → new_pc.
  - stall[0] → hold.
  - branch_flag_i → branch_target_address_i.
  - otherwise → pc_q + 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
- IF/ID update priority:
  - rst, or flush → all zero (pc=0, inst=0, valid=0, adel=0).
  - ce_q == 0 → all zero.
  - stall[1] & !stall[2] → bubble (all zero).
  - !stall[1] → capture {pc_q, aligned ? rom_data_i : 0, 1, !aligned}.
  - otherwise (stall[1] & stall[2]) → hold.
- Misaligned PC: ROM not enabled, NOP injected, adel flagged; the PC still advances normally so the exception stage can flush.
- Branch delay slot: branch_flag_i arrives while the delay-slot instruction is being fetched. That slot is captured normally and is not squashed; only the following fetch address changes.
- flush overrides stall and branch in the same cycle.

## Timing
- Reset values: rom_ce_o=0, rom_addr_o=RESET_PC, id_pc_o=0, id_inst_o=0, id_valid_o=0, id_adel_o=0.
- The ROM is read combinationally. The word addressed in cycle n is registered and appears on id_* in cycle n+1 (1-cycle latency).
- Redirect: branch_flag_i or flush high in cycle n → rom_addr_o = target in cycle n+1 → target instruction appears on id_* in cycle n+2.
- Stall is level-sensitive. PC and IF/ID resume on the first edge with the stall bits low; no instruction is lost or duplicated.
- Reset asserted mid-stream takes effect on the next edge regardless of stall/flush/branch. Fetch resumes at RESET_PC two edges after rst deasserts (one ce_q enable edge, one capture edge).

## Test plan
- Reset release, no stall, ROM = {w0,w1,w2}: cycle after rst drop has rom_ce_o=1, addr=0 → id_pc_o 0,4,8 with inst w0,w1,w2 and valid=1 on consecutive cycles.
- Branch: branch_flag_i=1, target=32'h100 while addr=8 → delay slot at 8 enters ID; next addr 32'h100; id_pc_o sequence 4,8,32'h100.
- Stall: stall=6'b000111 for 3 cycles at addr=0x10 → pc and id_* frozen; release → id_pc_o 0x10 then 0x14, no duplicate.
- IF-only stall: stall=6'b000011 → bubble (valid=0, inst=0) in IF/ID, PC held.
- Flush with stall and branch simultaneous: flush=1, new_pc=32'h20, stall=6'b000111, branch_flag_i=1 → next cycle addr=0x20 and IF/ID zeroed; id_pc_o=0x20 the cycle after.
- Misaligned and wrap: branch to 32'h102 → rom_ce_o=0, id_adel_o=1, id_inst_o=0. Separately, PC at 32'hFFFF_FFFC advances to 0.
